// File: rtl/ysyx_22050550_issue_stage.sv
// Issue stage: a hold register waits for scoreboard RAW clearance, then claims rd
// and moves the instruction into an output register handshaked to the EXU.
module ysyx_22050550_issue_stage #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [31:0]      in_inst,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [4:0]       in_rd,
  input  logic             in_use_rs1,
  input  logic             in_use_rs2,
  input  logic             in_wen,
  output logic             sb_valid,
  output logic [4:0]       sb_raddr1,
  output logic [4:0]       sb_raddr2,
  output logic [4:0]       sb_waddr,
  output logic             sb_wen,
  input  logic             sb_busy1,
  input  logic             sb_busy2,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [31:0]      out_inst,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic             out_wen,
  output logic [CNT_W-1:0] stall_cnt
);

  logic            h_valid_reg;
  logic [XLEN-1:0] h_pc_reg;
  logic [31:0]     h_inst_reg;
  logic [4:0]      h_rs1_reg;
  logic [4:0]      h_rs2_reg;
  logic [4:0]      h_rd_reg;
  logic            h_use_rs1_reg;
  logic            h_use_rs2_reg;
  logic            h_wen_reg;

  logic            out_valid_reg;
  logic [XLEN-1:0] out_pc_reg;
  logic [31:0]     out_inst_reg;
  logic [4:0]      out_rs1_reg;
  logic [4:0]      out_rs2_reg;
  logic [4:0]      out_rd_reg;
  logic            out_wen_reg;

  logic [CNT_W-1:0] stall_cnt_reg;

  logic hazard;
  logic o_free;
  logic issue;
  logic accept;

  always_comb begin
    hazard   = h_valid_reg & ((h_use_rs1_reg & sb_busy1) | (h_use_rs2_reg & sb_busy2));
    o_free   = !out_valid_reg | out_ready;
    issue    = h_valid_reg & !hazard & o_free & !flush;
    in_ready = !reset & !flush & (!h_valid_reg | issue);
    accept   = in_valid & in_ready;
    // x0 is hardwired, so it must never be marked busy
    sb_wen   = issue & h_wen_reg & (h_rd_reg != 5'd0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      h_valid_reg   <= 1'b0;
      h_pc_reg      <= '0;
      h_inst_reg    <= '0;
      h_rs1_reg     <= '0;
      h_rs2_reg     <= '0;
      h_rd_reg      <= '0;
      h_use_rs1_reg <= 1'b0;
      h_use_rs2_reg <= 1'b0;
      h_wen_reg     <= 1'b0;
      out_valid_reg <= 1'b0;
      out_pc_reg    <= '0;
      out_inst_reg  <= '0;
      out_rs1_reg   <= '0;
      out_rs2_reg   <= '0;
      out_rd_reg    <= '0;
      out_wen_reg   <= 1'b0;
      stall_cnt_reg <= '0;
    end else begin
      if (accept) begin
        h_valid_reg   <= 1'b1;
        h_pc_reg      <= in_pc;
        h_inst_reg    <= in_inst;
        h_rs1_reg     <= in_rs1;
        h_rs2_reg     <= in_rs2;
        h_rd_reg      <= in_rd;
        h_use_rs1_reg <= in_use_rs1;
        h_use_rs2_reg <= in_use_rs2;
        h_wen_reg     <= in_wen;
      end else if (issue || flush) begin
        h_valid_reg <= 1'b0;
      end

      if (issue) begin
        out_valid_reg <= 1'b1;
        out_pc_reg    <= h_pc_reg;
        out_inst_reg  <= h_inst_reg;
        out_rs1_reg   <= h_rs1_reg;
        out_rs2_reg   <= h_rs2_reg;
        out_rd_reg    <= h_rd_reg;
        out_wen_reg   <= h_wen_reg;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end

      if (hazard && !flush && (stall_cnt_reg != {CNT_W{1'b1}})) begin
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      end
    end
  end

  assign sb_valid  = h_valid_reg;
  assign sb_raddr1 = h_rs1_reg;
  assign sb_raddr2 = h_rs2_reg;
  assign sb_waddr  = h_rd_reg;
  assign out_valid = out_valid_reg;
  assign out_pc    = out_pc_reg;
  assign out_inst  = out_inst_reg;
  assign out_rs1   = out_rs1_reg;
  assign out_rs2   = out_rs2_reg;
  assign out_rd    = out_rd_reg;
  assign out_wen   = out_wen_reg;
  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_ysyx_22050550_issue_stage.sv
// Directed bench for the issue stage; the scoreboard busy lines are driven by hand.
module tb_ysyx_22050550_issue_stage;
  localparam int XLEN  = 64;
  localparam int CNT_W = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  in_pc;
  logic [31:0]      in_inst;
  logic [4:0]       in_rs1, in_rs2, in_rd;
  logic             in_use_rs1, in_use_rs2, in_wen;
  logic             sb_valid;
  logic [4:0]       sb_raddr1, sb_raddr2, sb_waddr;
  logic             sb_wen;
  logic             sb_busy1, sb_busy2;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_pc;
  logic [31:0]      out_inst;
  logic [4:0]       out_rs1, out_rs2, out_rd;
  logic             out_wen;
  logic [CNT_W-1:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  ysyx_22050550_issue_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2), .in_wen(in_wen),
    .sb_valid(sb_valid), .sb_raddr1(sb_raddr1), .sb_raddr2(sb_raddr2),
    .sb_waddr(sb_waddr), .sb_wen(sb_wen), .sb_busy1(sb_busy1), .sb_busy2(sb_busy2),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_rd(out_rd), .out_wen(out_wen), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [63:0] pc, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd,
                        input logic u1, input logic u2, input logic wen);
    in_valid   = v;
    in_pc      = pc;
    in_inst    = {pc[15:0], 16'h0013};
    in_rs1     = rs1;
    in_rs2     = rs2;
    in_rd      = rd;
    in_use_rs1 = u1;
    in_use_rs2 = u2;
    in_wen     = wen;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0; sb_busy1 = 1'b0; sb_busy2 = 1'b0;
    set_in(1'b0, 64'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    in_valid = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sb_valid", sb_valid, 0);
    chk("rst_sb_wen", sb_wen, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_rd", out_rd, 0);
    in_valid = 1'b0;
    tick();
    reset = 1'b0;

    // Independent stream of four instructions, rd = 1..4
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c < 4) set_in(1'b1, 64'h1000 + 4 * c, 5'd0, 5'd0, 5'(c + 1), 1'b0, 1'b0, 1'b1);
      else       set_in(1'b0, 64'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      #1;
      $display("stream cycle %0d: in_ready=%0b sb_wen=%0b sb_waddr=%0d out_valid=%0b out_rd=%0d",
               c, in_ready, sb_wen, sb_waddr, out_valid, out_rd);
      if (c < 4) chk("stream_in_ready", in_ready, 1);
      if (c >= 1 && c <= 4) begin
        chk("stream_sb_wen", sb_wen, 1);
        chk("stream_sb_waddr", sb_waddr, c);
      end else begin
        chk("stream_sb_wen_idle", sb_wen, 0);
      end
      if (c >= 2) begin
        chk("stream_out_valid", out_valid, 1);
        chk("stream_out_rd", out_rd, c - 1);
        chk("stream_out_pc", out_pc, 64'h1000 + 4 * (c - 2));
      end else begin
        chk("stream_out_valid_early", out_valid, 0);
      end
      tick();
    end
    chk("stream_out_valid_drain", out_valid, 0);
    chk("stream_stall_cnt", stall_cnt, 0);

    // RAW: A writes x5, B reads x5 and waits six busy cycles
    set_in(1'b1, 64'h2000, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1);
    #1; chk("raw_accept_a", in_ready, 1);
    tick();
    set_in(1'b1, 64'h2004, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1);
    #1;
    $display("raw issue A: sb_wen=%0b sb_waddr=%0d in_ready=%0b", sb_wen, sb_waddr, in_ready);
    chk("raw_a_sb_wen", sb_wen, 1);
    chk("raw_a_sb_waddr", sb_waddr, 5);
    chk("raw_accept_b", in_ready, 1);
    tick();
    in_valid = 1'b0;
    sb_busy1 = 1'b1;
    for (int s = 0; s < 6; s++) begin
      #1;
      $display("raw stall %0d: in_ready=%0b sb_wen=%0b stall_cnt=%0d", s, in_ready, sb_wen, stall_cnt);
      chk("raw_stall_in_ready", in_ready, 0);
      chk("raw_stall_sb_wen", sb_wen, 0);
      chk("raw_stall_raddr1", sb_raddr1, 5);
      chk("raw_stall_cnt_run", stall_cnt, s);
      tick();
    end
    sb_busy1 = 1'b0;
    #1;
    $display("raw release: sb_wen=%0b sb_waddr=%0d stall_cnt=%0d", sb_wen, sb_waddr, stall_cnt);
    chk("raw_stall_cnt", stall_cnt, 6);
    chk("raw_b_sb_wen", sb_wen, 1);
    chk("raw_b_sb_waddr", sb_waddr, 6);
    tick();
    chk("raw_b_out_valid", out_valid, 1);
    chk("raw_b_out_pc", out_pc, 64'h2004);
    chk("raw_b_sb_valid", sb_valid, 0);
    chk("raw_stall_cnt_hold", stall_cnt, 6);

    // Backpressure: O holds B while EXU is not ready
    out_ready = 1'b0;
    set_in(1'b1, 64'h3000, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1);
    #1; chk("bp_accept_c", in_ready, 1);
    tick();
    set_in(1'b1, 64'h3004, 5'd0, 5'd0, 5'd8, 1'b0, 1'b0, 1'b1);
    for (int b = 0; b < 3; b++) begin
      #1;
      $display("bp cycle %0d: in_ready=%0b sb_wen=%0b out_pc=%0h", b, in_ready, sb_wen, out_pc);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_sb_wen", sb_wen, 0);
      chk("bp_out_pc", out_pc, 64'h2004);
      chk("bp_out_rd", out_rd, 6);
      chk("bp_out_valid", out_valid, 1);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_sb_wen", sb_wen, 1);
    chk("bp_release_waddr", sb_waddr, 7);
    chk("bp_release_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("bp_out_c", out_pc, 64'h3000);
    chk("bp_d_waddr", sb_waddr, 8);
    tick();

    // Flush a stalled instruction while O holds D
    out_ready = 1'b0;
    set_in(1'b1, 64'h4000, 5'd0, 5'd9, 5'd10, 1'b0, 1'b1, 1'b1);
    #1; chk("fl_accept_e", in_ready, 1);
    tick();
    in_valid = 1'b0;
    sb_busy2 = 1'b1;
    #1;
    chk("fl_stall_sb_wen", sb_wen, 0);
    chk("fl_stall_in_ready", in_ready, 0);
    tick();
    chk("fl_stall_cnt", stall_cnt, 7);
    flush = 1'b1;
    set_in(1'b1, 64'h4004, 5'd0, 5'd0, 5'd11, 1'b0, 1'b0, 1'b1);
    #1;
    $display("flush cycle: in_ready=%0b sb_wen=%0b", in_ready, sb_wen);
    chk("fl_in_ready", in_ready, 0);
    chk("fl_sb_wen", sb_wen, 0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    sb_busy2 = 1'b0;
    #1;
    chk("fl_sb_valid", sb_valid, 0);
    chk("fl_sb_wen_after", sb_wen, 0);
    chk("fl_out_valid", out_valid, 1);
    chk("fl_out_pc", out_pc, 64'h3004);
    chk("fl_stall_cnt_hold", stall_cnt, 7);

    // x0: rd=0 is never claimed, reads of x0 never stall
    out_ready = 1'b1;
    set_in(1'b1, 64'h5000, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    #1; chk("x0_accept", in_ready, 1);
    tick();
    set_in(1'b1, 64'h5004, 5'd0, 5'd0, 5'd12, 1'b1, 1'b0, 1'b1);
    #1;
    $display("x0 issue: sb_wen=%0b in_ready=%0b", sb_wen, in_ready);
    chk("x0_sb_wen", sb_wen, 0);
    chk("x0_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("x0_out_rd", out_rd, 0);
    chk("x0_out_wen", out_wen, 1);
    chk("x0_out_pc", out_pc, 64'h5000);
    chk("x0_read_sb_wen", sb_wen, 1);
    chk("x0_read_waddr", sb_waddr, 12);
    tick();
    chk("x0_read_out_pc", out_pc, 64'h5004);
    chk("x0_stall_cnt", stall_cnt, 7);

    // Counter saturation at 4'hF, then reset
    set_in(1'b1, 64'h6000, 5'd13, 5'd0, 5'd14, 1'b1, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    sb_busy1 = 1'b1;
    for (int k = 0; k < 20; k++) tick();
    $display("saturation: stall_cnt=%0d", stall_cnt);
    chk("sat_stall_cnt", stall_cnt, 15);
    chk("sat_sb_valid", sb_valid, 1);
    reset = 1'b1;
    tick();
    #1;
    chk("sat_rst_stall_cnt", stall_cnt, 0);
    chk("sat_rst_sb_valid", sb_valid, 0);
    chk("sat_rst_out_valid", out_valid, 0);
    chk("sat_rst_in_ready", in_ready, 0);
    chk("sat_rst_out_pc", out_pc, 0);
    reset = 1'b0;
    sb_busy1 = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ysyx_22050550_issue_stage.md
# ysyx_22050550_issue_stage

Decode-to-execute issue stage for the ysyx_22050550 pipeline. Latches decoded instructions from the IDU decoder into a hold register and queries the register scoreboard for RAW hazards on the source registers. On a clear path it claims the destination register in the scoreboard and moves the instruction into an output register that feeds the EXU through a valid/ready handshake. It also keeps a saturating hazard-stall performance counter.

## Interface
- XLEN, 64, width of PC
- CNT_W, 32, width of stall counter
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  decoded instruction offered
- in_ready  out  1  stage accepts the offered instruction this cycle
- in_pc  in  XLEN  instruction PC
- in_inst  in  32  raw instruction
- in_rs1, in_rs2, in_rd  in  5 each  source/dest register indices
- in_use_rs1, in_use_rs2  in  1 each  source register is actually read
- in_wen  in  1  instruction writes rd
- sb_valid  out  1  hold register occupied (drives scoreboard io_IDU_valid)
- sb_raddr1, sb_raddr2  out  5 each  hold-register rs1/rs2
- sb_waddr  out  5  hold-register rd
- sb_wen  out  1  claim rd busy (one-cycle pulse at issue)
- sb_busy1, sb_busy2  in  1 each  scoreboard busy for raddr1/raddr2
- flush  in  1  kill the hold-register instruction
- out_valid  out  1  instruction available to EXU
- out_ready  in  1  EXU accepts
- out_pc, out_inst, out_rs1, out_rs2, out_rd, out_wen  out  as inputs  issued instruction
- stall_cnt  out  CNT_W  hazard stall cycles, saturating

## Operation
- Two registers: hold H (h_valid + fields) and output O (out_valid + fields).
- hazard = h_valid & ((in_use_rs1 latched & sb_busy1) | (in_use_rs2 latched & sb_busy2)).
- o_free = !out_valid | out_ready.
- issue = h_valid & !hazard & o_free & !flush.
- sb_wen = issue & h.wen & (h.rd != 0). It is combinational, so the scoreboard sets busy at the same edge O loads.
- in_ready = !reset & !flush & (!h_valid | issue). This allows back-to-back accept while issuing.
- Accept (in_valid & in_ready): H loads the input fields and h_valid becomes 1.
- Issue without a new accept: h_valid becomes 0.
- Issue: O loads H and out_valid becomes 1.
- EXU takes (out_valid & out_ready) with no issue in the same cycle: out_valid becomes 0.
- O fields are stable while out_valid & !out_ready.
- flush: h_valid becomes 0 next edge and no accept occurs that cycle. O is unaffected, because an instruction in O has already claimed the scoreboard and must complete.
- stall_cnt increments when h_valid & hazard & !flush. It holds at all-ones.
- x0 is never claimed. Reads of x0 never stall, because the scoreboard reports x0 as never busy.

## Timing
- Reset values: h_valid=0, out_valid=0, in_ready=0 while reset is high, sb_wen=0, sb_valid=0, stall_cnt=0. All O fields are 0.
- Latency: instruction accepted at edge t, visible in H during cycle t+1, out_valid at t+2 when hazard-free and O is free.
- Throughput: 1 instruction/cycle with no hazards and out_ready held high.
- Dependent back-to-back pair (rd of A = rs1 of B):
  - B is in H during the cycle after A issues.
  - The scoreboard busy is already set, so B stalls until the WBU clears the bit.
  - B issues in the first cycle in which sb_busy1=0.
- A WBU clear and a busy read in the same cycle still reads busy=1. This costs one extra stall cycle by design.
- flush together with issue-eligible H: no issue and no sb_wen. H is killed.
- Reset mid-operation clears H, O and the counter at the next edge, regardless of handshakes.

## Test plan
- Independent stream: 4 instructions (rd=1..4, no sources used), in_valid and out_ready held at 1 -> out_valid from cycle 2, one issue per cycle, sb_wen pulses with sb_waddr=1,2,3,4, stall_cnt=0.
- RAW stall: A writes x5; B reads x5 (in_use_rs1=1); scoreboard holds busy for 6 cycles -> B is held with in_ready=0, stall_cnt=6, and B issues in the first cycle after busy clears.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> O fields are constant, H fills once, in_ready=0 afterwards, and no sb_wen pulses.
- Flush: flush asserted while H holds a stalled instruction -> h_valid=0 next cycle, no sb_wen, O contents unchanged, in_ready=0 during the flush cycle.
- x0 handling: instruction with rd=0 and in_wen=1 -> issues with sb_wen=0. Instruction reading x0 -> no stall.
- Counter saturation: force stall_cnt near all-ones (CNT_W=4, 20 stall cycles) -> stall_cnt stops at 15. Reset then returns it to 0.
